// File: rtl/regalu_arbiter_if.sv
// Request/response and register-file control bundle between two requesters, the arbiter and RegFile_Alu.
// slave is the arbiter's view; master is the view of the environment (requesters plus register file).
interface regalu_arbiter_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4,
    parameter int OP_W   = 4,
    parameter int FLAG_W = 5
);
    logic              ReqA, ReqB;
    logic [OP_W-1:0]   OpCodeA, OpCodeB;
    logic [ADDR_W-1:0] RdestA, RdestB;
    logic [ADDR_W-1:0] RsrcA, RsrcB;
    logic [DATA_W-1:0] ImmA, ImmB;
    logic              ImmSA, ImmSB;
    logic              AckA, AckB;
    logic              DoneA, DoneB;
    logic [DATA_W-1:0] Result;
    logic [FLAG_W-1:0] ResultFlags;
    logic              Busy;
    logic [ADDR_W-1:0] RdestRegLoc, RsrcRegLoc;
    logic [OP_W-1:0]   OpCode;
    logic [DATA_W-1:0] Imm;
    logic              Imm_s;
    logic              En;
    logic [DATA_W-1:0] RdestOut;
    logic [FLAG_W-1:0] Flags;

    modport slave (
        input  ReqA, ReqB, OpCodeA, OpCodeB, RdestA, RdestB, RsrcA, RsrcB,
               ImmA, ImmB, ImmSA, ImmSB, RdestOut, Flags,
        output AckA, AckB, DoneA, DoneB, Result, ResultFlags, Busy,
               RdestRegLoc, RsrcRegLoc, OpCode, Imm, Imm_s, En
    );

    modport master (
        output ReqA, ReqB, OpCodeA, OpCodeB, RdestA, RdestB, RsrcA, RsrcB,
               ImmA, ImmB, ImmSA, ImmSB, RdestOut, Flags,
        input  AckA, AckB, DoneA, DoneB, Result, ResultFlags, Busy,
               RdestRegLoc, RsrcRegLoc, OpCode, Imm, Imm_s, En
    );
endinterface

// File: rtl/regalu_arbiter.sv
// Round-robin two-port arbiter/sequencer driving RegFile_Alu; Ack 1 cycle after Req, Done 3 cycles after Req.
// Requesters hold Req until Ack; one operation in flight, next grant no earlier than 4 cycles after the last.
module regalu_arbiter #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4,
    parameter int OP_W   = 4,
    parameter int FLAG_W = 5
) (
    input  logic         Clk,
    input  logic         Rst,
    regalu_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, EXEC, READ, DONE} state_t;

    state_t            state_q, state_d;
    logic              prio_q, prio_d;
    logic              owner_q, owner_d;
    logic              en_q, en_d;
    logic              ack_a_q, ack_a_d, ack_b_q, ack_b_d;
    logic              done_a_q, done_a_d, done_b_q, done_b_d;
    logic              busy_q, busy_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic [FLAG_W-1:0] result_flags_q, result_flags_d;
    logic [ADDR_W-1:0] rdest_q, rdest_d, rsrc_q, rsrc_d;
    logic [OP_W-1:0]   opcode_q, opcode_d;
    logic [DATA_W-1:0] imm_q, imm_d;
    logic              imm_s_q, imm_s_d;
    logic              grant_b;

    always_comb begin
        state_d        = state_q;
        prio_d         = prio_q;
        owner_d        = owner_q;
        en_d           = 1'b0;
        ack_a_d        = 1'b0;
        ack_b_d        = 1'b0;
        done_a_d       = 1'b0;
        done_b_d       = 1'b0;
        busy_d         = busy_q;
        result_d       = result_q;
        result_flags_d = result_flags_q;
        rdest_d        = rdest_q;
        rsrc_d         = rsrc_q;
        opcode_d       = opcode_q;
        imm_d          = imm_q;
        imm_s_d        = imm_s_q;
        grant_b        = bus.ReqB && (!bus.ReqA || prio_q);

        case (state_q)
            IDLE: begin
                if (bus.ReqA || bus.ReqB) begin
                    owner_d  = grant_b;
                    // Winner yields priority to the other port for the next contention.
                    prio_d   = !grant_b;
                    rdest_d  = grant_b ? bus.RdestB  : bus.RdestA;
                    rsrc_d   = grant_b ? bus.RsrcB   : bus.RsrcA;
                    opcode_d = grant_b ? bus.OpCodeB : bus.OpCodeA;
                    imm_d    = grant_b ? bus.ImmB    : bus.ImmA;
                    imm_s_d  = grant_b ? bus.ImmSB   : bus.ImmSA;
                    en_d     = 1'b1;
                    ack_a_d  = !grant_b;
                    ack_b_d  = grant_b;
                    busy_d   = 1'b1;
                    state_d  = EXEC;
                end
            end
            EXEC: begin
                result_flags_d = bus.Flags;
                state_d        = READ;
            end
            READ: begin
                // The write landed at the end of EXEC, so RdestOut now shows the new value.
                result_d = bus.RdestOut;
                done_a_d = !owner_q;
                done_b_d = owner_q;
                state_d  = DONE;
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q        <= IDLE;
            prio_q         <= 1'b0;
            owner_q        <= 1'b0;
            en_q           <= 1'b0;
            ack_a_q        <= 1'b0;
            ack_b_q        <= 1'b0;
            done_a_q       <= 1'b0;
            done_b_q       <= 1'b0;
            busy_q         <= 1'b0;
            result_q       <= '0;
            result_flags_q <= '0;
            rdest_q        <= '0;
            rsrc_q         <= '0;
            opcode_q       <= '0;
            imm_q          <= '0;
            imm_s_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            prio_q         <= prio_d;
            owner_q        <= owner_d;
            en_q           <= en_d;
            ack_a_q        <= ack_a_d;
            ack_b_q        <= ack_b_d;
            done_a_q       <= done_a_d;
            done_b_q       <= done_b_d;
            busy_q         <= busy_d;
            result_q       <= result_d;
            result_flags_q <= result_flags_d;
            rdest_q        <= rdest_d;
            rsrc_q         <= rsrc_d;
            opcode_q       <= opcode_d;
            imm_q          <= imm_d;
            imm_s_q        <= imm_s_d;
        end
    end

    assign bus.En          = en_q;
    assign bus.AckA        = ack_a_q;
    assign bus.AckB        = ack_b_q;
    assign bus.DoneA       = done_a_q;
    assign bus.DoneB       = done_b_q;
    assign bus.Busy        = busy_q;
    assign bus.Result      = result_q;
    assign bus.ResultFlags = result_flags_q;
    assign bus.RdestRegLoc = rdest_q;
    assign bus.RsrcRegLoc  = rsrc_q;
    assign bus.OpCode      = opcode_q;
    assign bus.Imm         = imm_q;
    assign bus.Imm_s       = imm_s_q;
endmodule
